// File: rtl/tag_sram_pkg.sv
// Shared defaults and enums for the tag SRAM access controller.
// The optional post-reset clear sweep is enabled by defining TAG_SRAM_CLEAR_EN.
package tag_sram_pkg;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 64;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } tag_sram_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_WR
  } tag_sram_grant_e;

endpackage

// File: rtl/tag_sram_rr_arb.sv
// Two-way round-robin arbiter between the lookup read and refill write ports.
// Handshake: a requester is served in the cycle its one-hot grant bit is high.
module tag_sram_rr_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       req_rd,
  input  logic       req_wr,
  output logic [1:0] gnt      // [0] read, [1] write
);

  logic last_wr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req_rd && (!req_wr || last_wr)) gnt = 2'b01;
      else if (req_wr)                    gnt = 2'b10;
    end
  end

  // Pointer moves only on contention; starting at "write last" lets a read win first.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_wr <= 1'b1;
    end else if (en && req_rd && req_wr) begin
      last_wr <= gnt[1];
    end
  end

endmodule

// File: rtl/tag_sram_ctrl.sv
// Single-port controller for a 32x64 tag SRAM macro: read/write arbitration,
// one-cycle read response, optional post-reset clear sweep (TAG_SRAM_CLEAR_EN).
module tag_sram_ctrl #(
  parameter int ADDR_W = tag_sram_pkg::ADDR_W,
  parameter int DEPTH  = tag_sram_pkg::DEPTH,
  parameter int DATA_W = tag_sram_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_A,
  output logic              sram_CSB,
  output logic              sram_WEB,
  output logic              sram_OEB,
  output logic [DATA_W-1:0] sram_I,
  input  logic [DATA_W-1:0] sram_O
);

  import tag_sram_pkg::*;

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("tag_sram_ctrl: DEPTH must equal 2**ADDR_W");
  end

  logic              run;
  logic              sweep;
  logic [ADDR_W-1:0] sweep_idx;
  logic [1:0]        gnt;
  tag_sram_grant_e   grant;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] i_q;
  logic              resp_q;

`ifdef TAG_SRAM_CLEAR_EN
  tag_sram_state_e   state_q, state_d;
  logic [ADDR_W-1:0] clr_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      clr_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && clr_idx == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
  end

  assign run       = (state_q == ST_RUN);
  assign sweep     = (state_q == ST_INIT) && !reset;
  assign sweep_idx = clr_idx;
  assign init_done = run;
`else
  assign run       = 1'b1;
  assign sweep     = 1'b0;
  assign sweep_idx = '0;
  assign init_done = 1'b1;
`endif

  tag_sram_rr_arb u_arb (
    .clock  (clock),
    .reset  (reset),
    .en     (run && !reset),
    .req_rd (rd_valid),
    .req_wr (wr_valid),
    .gnt    (gnt)
  );

  always_comb begin
    grant = GNT_NONE;
    if (gnt[0])      grant = GNT_RD;
    else if (gnt[1]) grant = GNT_WR;
  end

  // Idle cycles replay the last address/data so the macro inputs stay quiet.
  always_comb begin
    sram_CSB = 1'b1;
    sram_WEB = 1'b1;
    sram_A   = a_q;
    sram_I   = i_q;
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    if (sweep) begin
      sram_CSB = 1'b0;
      sram_WEB = 1'b0;
      sram_A   = sweep_idx;
      sram_I   = '0;
    end else begin
      case (grant)
        GNT_RD: begin
          sram_CSB = 1'b0;
          sram_A   = rd_addr;
          rd_ready = 1'b1;
        end
        GNT_WR: begin
          sram_CSB = 1'b0;
          sram_WEB = 1'b0;
          sram_A   = wr_addr;
          sram_I   = wr_data;
          wr_ready = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q    <= '0;
      i_q    <= '0;
      resp_q <= 1'b0;
    end else begin
      a_q    <= sram_A;
      i_q    <= sram_I;
      resp_q <= (grant == GNT_RD);
    end
  end

  // A reset arriving while a response is pending suppresses it immediately.
  assign rd_resp_valid = resp_q && !reset;
  assign sram_OEB      = !rd_resp_valid;
  assign rd_resp_data  = rd_resp_valid ? sram_O : '0;

endmodule
